// File: rtl/sorted_lists_table_if.sv
// ---------------------------------------------------------------------------
// sorted_lists_table_if
//
// Bundles the update/commit handshake and the snapshot publish signals of
// sorted_lists_table. Clock and reset are not part of the bundle.
//
// Widths are carried as plain vectors so this file has no package dependency;
// the defaults match $bits(entry_t) and $bits(table_state_t) from
// sorted_lists_table_pkg.
//
//   upd_vld        master -> slave  update request
//   upd_rdy        slave  -> master update accepted when upd_vld & upd_rdy
//   upd_idx        master -> slave  table slot to overwrite
//   upd_entry      master -> slave  new entry for that slot (entry_t)
//   commit         master -> slave  single-cycle publish request
//   unsorted_valid slave  -> master publish strobe
//   unsorted       slave  -> master published snapshot (table_state_t)
//   sorted_vld     slave  -> master sorter result is stable on sorted_r
//   busy           slave  -> master a snapshot is in flight
// ---------------------------------------------------------------------------
interface sorted_lists_table_if #(
  parameter int ENTRY_W = 16,
  parameter int TABLE_W = 64
);
  logic               upd_vld;
  logic               upd_rdy;
  logic [1:0]         upd_idx;
  logic [ENTRY_W-1:0] upd_entry;
  logic               commit;
  logic               unsorted_valid;
  logic [TABLE_W-1:0] unsorted;
  logic               sorted_vld;
  logic               busy;

  modport master (
    output upd_vld, upd_idx, upd_entry, commit,
    input  upd_rdy, unsorted_valid, unsorted, sorted_vld, busy
  );

  modport slave (
    input  upd_vld, upd_idx, upd_entry, commit,
    output upd_rdy, unsorted_valid, unsorted, sorted_vld, busy
  );
endinterface

// File: rtl/sorted_lists_table.sv
// ---------------------------------------------------------------------------
// sorted_lists_table
//
// Holds the live 4-entry table, applies single-entry updates and publishes
// whole-table snapshots to the downstream sorting network. Publishes are
// paced so only one snapshot is in flight through the sorter at a time, and
// sorted_vld marks the cycle the sorter's sorted_r holds that snapshot's
// result.
//
// Parameters:
//   SORT_LAT         sorter latency from unsorted_valid to a stable sorted_r;
//                    also the minimum spacing between publishes.
//   AUTO_PUB_CYCLES  idle cycles in DIRTY before an automatic publish.
//
// Compile-time option:
//   SORTED_LISTS_AUTO_PUBLISH_EN  when defined, a dirty table with no
//                    accepted update for AUTO_PUB_CYCLES cycles publishes on
//                    its own. When undefined, a dirty table waits for commit.
//
// Ports:
//   clk   clock, everything is sampled on its rising edge
//   rst   synchronous active-high reset
//   bus   sorted_lists_table_if.slave (update handshake, commit, publish)
// ---------------------------------------------------------------------------
package sorted_lists_table_pkg;
  typedef struct packed {
    logic [7:0] key;
    logic [7:0] payload;
  } entry_t;

  typedef struct packed {
    entry_t [3:0] e;
  } table_state_t;
endpackage

module sorted_lists_table
  import sorted_lists_table_pkg::*;
#(
  parameter int SORT_LAT        = 5,
  parameter int AUTO_PUB_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sorted_lists_table_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DIRTY = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int HOLD_W = (SORT_LAT > 1) ? $clog2(SORT_LAT + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SORT_LAT - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_q, state_d;
  table_state_t        tbl_q, tbl_d;
  logic [3:0]          dirty_q, dirty_d;
  logic                commit_pend_q, commit_pend_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                unsorted_valid_q, unsorted_valid_d;
  table_state_t        unsorted_q, unsorted_d;
  logic [SORT_LAT-1:0] vld_sr_q, vld_sr_d;

  // -------------------------------------------------------------------------
  // Update path
  // -------------------------------------------------------------------------
  entry_t       upd_entry;
  logic         upd_rdy;
  logic         upd_fire;
  logic [3:0]   upd_mask;
  entry_t [3:0] wt_e;
  table_state_t tbl_wt;
  logic         publish;
  logic         auto_fire;

  assign upd_entry = bus.upd_entry;
  assign upd_rdy   = (state_q != ST_INIT);
  assign upd_fire  = bus.upd_vld & upd_rdy;

  // tbl_wt is the table with this cycle's accepted update merged in. It is
  // both the next table value and the snapshot source, so an update in the
  // same cycle as a publish trigger is included in that publish.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_slot
    logic hit;
    assign hit          = upd_fire && (bus.upd_idx == 2'(gi));
    assign upd_mask[gi] = hit;
    assign wt_e[gi]     = hit ? upd_entry : tbl_q.e[gi];
  end

  assign tbl_wt.e = wt_e;
  assign tbl_d    = tbl_wt;

  // -------------------------------------------------------------------------
  // Auto-publish timer
  // -------------------------------------------------------------------------
`ifdef SORTED_LISTS_AUTO_PUBLISH_EN
  localparam int IDLE_W = (AUTO_PUB_CYCLES > 1) ? $clog2(AUTO_PUB_CYCLES + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(AUTO_PUB_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  // idle_cnt_q counts completed update-free cycles in DIRTY, so the trigger
  // fires during the AUTO_PUB_CYCLES-th such cycle.
  assign auto_fire = (state_q == ST_DIRTY) && !upd_fire && (idle_cnt_q == IDLE_LAST);
`else
  assign auto_fire = 1'b0;

  // Without auto-publish the timeout parameter has no effect.
  if (AUTO_PUB_CYCLES < 0) begin : g_auto_pub_unused
  end
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    dirty_d       = dirty_q | upd_mask;
    commit_pend_d = commit_pend_q;
    hold_cnt_d    = hold_cnt_q;
    publish       = 1'b0;
`ifdef SORTED_LISTS_AUTO_PUBLISH_EN
    idle_cnt_d    = '0;
`endif

    case (state_q)
      // Push the cleared table once so the sorter pipeline holds defined data.
      ST_INIT: begin
        publish = 1'b1;
      end

      // A commit while clean still republishes.
      ST_IDLE: begin
        if (bus.commit) begin
          publish = 1'b1;
        end else if (upd_fire) begin
          state_d = ST_DIRTY;
        end
      end

      ST_DIRTY: begin
        if (bus.commit || commit_pend_q || auto_fire) begin
          publish = 1'b1;
        end
`ifdef SORTED_LISTS_AUTO_PUBLISH_EN
        else begin
          idle_cnt_d = upd_fire ? '0 : idle_cnt_q + 1'b1;
        end
`endif
      end

      // Triggers during the hold window are folded into commit_pend and
      // served by a single publish when the window closes.
      ST_HOLD: begin
        if (bus.commit) begin
          commit_pend_d = 1'b1;
        end
        if (hold_cnt_q == '0) begin
          if (commit_pend_q || bus.commit) begin
            publish = 1'b1;
          end else if (dirty_d != 4'b0000) begin
            state_d = ST_DIRTY;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Every publish path shares the same bookkeeping; the snapshot already
    // carries any same-cycle update, so nothing stays dirty.
    if (publish) begin
      state_d       = ST_HOLD;
      dirty_d       = 4'b0000;
      commit_pend_d = 1'b0;
      hold_cnt_d    = HOLD_LOAD;
    end
  end

  assign unsorted_valid_d = publish;
  assign unsorted_d       = publish ? tbl_wt : unsorted_q;

  // sorted_vld is the publish strobe delayed by the sorter latency.
  for (gi = 0; gi < SORT_LAT; gi++) begin : g_vld_sr
    if (gi == 0) begin : g_head
      assign vld_sr_d[gi] = unsorted_valid_q;
    end else begin : g_tail
      assign vld_sr_d[gi] = vld_sr_q[gi-1];
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_INIT;
      tbl_q            <= '0;
      dirty_q          <= '0;
      commit_pend_q    <= 1'b0;
      hold_cnt_q       <= '0;
      unsorted_valid_q <= 1'b0;
      unsorted_q       <= '0;
      vld_sr_q         <= '0;
`ifdef SORTED_LISTS_AUTO_PUBLISH_EN
      idle_cnt_q       <= '0;
`endif
    end else begin
      state_q          <= state_d;
      tbl_q            <= tbl_d;
      dirty_q          <= dirty_d;
      commit_pend_q    <= commit_pend_d;
      hold_cnt_q       <= hold_cnt_d;
      unsorted_valid_q <= unsorted_valid_d;
      unsorted_q       <= unsorted_d;
      vld_sr_q         <= vld_sr_d;
`ifdef SORTED_LISTS_AUTO_PUBLISH_EN
      idle_cnt_q       <= idle_cnt_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.upd_rdy        = upd_rdy;
  assign bus.unsorted_valid = unsorted_valid_q;
  assign bus.unsorted       = unsorted_q;
  assign bus.sorted_vld     = vld_sr_q[SORT_LAT-1];
  assign bus.busy           = (state_q == ST_HOLD);

endmodule
